// File: rtl/key_event_if.sv
// Key event bundle between the debouncer side and the classifier.
// Carries debounced key flag/level in and classified events out.
interface key_event_if;
  logic       key_flag;
  logic       key_state;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       key_held;

  modport master (
    output key_flag,
    output key_state,
    input  evt_valid,
    input  evt_code,
    input  key_held
  );

  modport slave (
    input  key_flag,
    input  key_state,
    output evt_valid,
    output evt_code,
    output key_held
  );
endinterface

// File: rtl/key_event_classifier.sv
// Key gesture classifier: short, long, double click, auto-repeat.
// One shared interval counter times every state.
module key_event_classifier #(
  parameter int LONG_CNT   = 24_000_000,
  parameter int DBL_CNT    = 7_200_000,
  parameter int REPEAT_CNT = 2_400_000,
  parameter int CNT_W      = 25
) (
  input logic        clk,
  input logic        rst_n,
  key_event_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    LONG_HOLD = 3'd2,
    WAIT2     = 3'd3,
    PRESS2    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CNT - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CNT - 1);

  localparam logic [1:0] C_SHORT  = 2'b00;
  localparam logic [1:0] C_LONG   = 2'b01;
  localparam logic [1:0] C_DOUBLE = 2'b10;
  localparam logic [1:0] C_REPEAT = 2'b11;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             evt_n;
  logic [1:0]       code_n;
  logic             rep_hit;
  logic             held_n;
  logic             press_ev, release_ev;

  assign press_ev   = bus.key_flag & ~bus.key_state;
  assign release_ev = bus.key_flag &  bus.key_state;

  // Next state and event; key events take priority over timeouts
  always_comb begin
    state_n = state;
    evt_n   = 1'b0;
    code_n  = bus.evt_code;
    rep_hit = 1'b0;
    case (state)
      IDLE: begin
        if (press_ev) state_n = PRESS1;
      end
      PRESS1: begin
        if (release_ev) begin
          state_n = WAIT2;
        end else if (cnt == LONG_TC) begin
          state_n = LONG_HOLD;
          evt_n   = 1'b1;
          code_n  = C_LONG;
        end
      end
      LONG_HOLD: begin
        if (release_ev) begin
          state_n = IDLE;
        end else if (cnt == REP_TC) begin
          evt_n   = 1'b1;
          code_n  = C_REPEAT;
          rep_hit = 1'b1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_n = PRESS2;
          evt_n   = 1'b1;
          code_n  = C_DOUBLE;
        end else if (cnt == DBL_TC) begin
          state_n = IDLE;
          evt_n   = 1'b1;
          code_n  = C_SHORT;
        end
      end
      PRESS2: begin
        if (release_ev) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter restarts on any state change, repeat tick, or untimed state
  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    if (state_n != state || rep_hit ||
        state_n == IDLE || state_n == PRESS2)
      cnt_n = '0;
  end

  assign held_n = (state_n == PRESS1) ||
                  (state_n == LONG_HOLD) ||
                  (state_n == PRESS2);

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.evt_valid <= 1'b0;
      bus.evt_code  <= 2'b00;
      bus.key_held  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bus.evt_valid <= evt_n;
      bus.evt_code  <= code_n;
      bus.key_held  <= held_n;
    end
  end

endmodule
